// File: rtl/pll_reset_ctrl_if.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl_if
// Signal bundle between the PLL reset sequencer and its surroundings
// (the PLL itself plus the downstream logic it holds in reset).
//   PLL_LOCK : PLL lock indication, asynchronous to the reference clock
//   RESTART  : one-cycle synchronous request to resequence the PLL
//   PLL_RST  : PLL reset, active high
//   DS_RSTN  : downstream reset, active low
//   READY    : PLL locked and stable
//   FAULT    : all reset attempts used up without a stable lock
//   STATE    : current sequencer state (0..4)
// slave  : the sequencer side
// master : the PLL / system side
// ---------------------------------------------------------------------------
interface pll_reset_ctrl_if;
    logic       PLL_LOCK;
    logic       RESTART;
    logic       PLL_RST;
    logic       DS_RSTN;
    logic       READY;
    logic       FAULT;
    logic [2:0] STATE;

    modport slave (
        input  PLL_LOCK, RESTART,
        output PLL_RST, DS_RSTN, READY, FAULT, STATE
    );

    modport master (
        output PLL_LOCK, RESTART,
        input  PLL_RST, DS_RSTN, READY, FAULT, STATE
    );
endinterface

// File: rtl/pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl
// Sequences PLL start-up from the PLL reference clock: pulses PLL_RST, waits
// for lock, requires lock to stay up for LOCK_STABLE cycles, then releases the
// downstream reset. A lock that never arrives within LOCK_TIMEOUT triggers a
// retry; after MAX_RETRY retries the block parks in FAULT with PLL_RST held.
// Ports:
//   CLKI  : PLL reference clock, all logic on its rising edge
//   RSTN  : asynchronous active-low reset (release synchronized externally)
//   pll   : slave side of pll_reset_ctrl_if (PLL_LOCK/RESTART in,
//           PLL_RST/DS_RSTN/READY/FAULT/STATE out)
// ---------------------------------------------------------------------------
module pll_reset_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3
) (
    input  logic             CLKI,
    input  logic             RSTN,
    pll_reset_ctrl_if.slave  pll
);

    localparam int MAX_AB = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_P) + 1;
    localparam int RTY_W  = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic             lock_meta, lock_s;
    logic             cnt_clr, retry_inc, retry_clr;
    logic             pll_rst_q, ds_rstn_q, ready_q, fault_q;

    // Two-flop synchronizer; lock_s is the only view of PLL_LOCK used below.
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll.PLL_LOCK;
            lock_s    <= lock_meta;
        end
    end

    // Next-state logic. cnt_clr marks every state entry (including a RESTART
    // while already in RESET_PLL) so the shared counter always starts at 0.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        if (pll.RESTART) begin
            next_state = S_RESET_PLL;
            cnt_clr    = 1'b1;
            retry_clr  = 1'b1;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        next_state = S_WAIT_LOCK;
                        cnt_clr    = 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        next_state = S_STABLE;
                        cnt_clr    = 1'b1;
                    end else if (cnt == TO_LAST) begin
                        cnt_clr = 1'b1;
                        if (retry_cnt == RTY_MAX) begin
                            next_state = S_FAULT;
                        end else begin
                            next_state = S_RESET_PLL;
                            retry_inc  = 1'b1;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        next_state = S_WAIT_LOCK;
                        cnt_clr    = 1'b1;
                    end else if (cnt == STB_LAST) begin
                        next_state = S_RUN;
                        cnt_clr    = 1'b1;
                        retry_clr  = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        next_state = S_RESET_PLL;
                        cnt_clr    = 1'b1;
                    end
                end
                S_FAULT: begin
                    next_state = S_FAULT;
                end
                default: begin
                    next_state = S_RESET_PLL;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    // State, counter, retry count and outputs. Outputs are decoded from
    // next_state so they change on the same edge as the state itself.
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst_q <= 1'b1;
            ds_rstn_q <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state <= next_state;

            if (cnt_clr)
                cnt <= '0;
            else if (state == S_RESET_PLL || state == S_WAIT_LOCK || state == S_STABLE)
                cnt <= cnt + 1'b1;

            if (retry_clr)
                retry_cnt <= '0;
            else if (retry_inc && retry_cnt != RTY_MAX)
                retry_cnt <= retry_cnt + 1'b1;

            pll_rst_q <= (next_state == S_RESET_PLL) || (next_state == S_FAULT);
            ds_rstn_q <= (next_state == S_RUN);
            ready_q   <= (next_state == S_RUN);
            fault_q   <= (next_state == S_FAULT);
        end
    end

    assign pll.PLL_RST = pll_rst_q;
    assign pll.DS_RSTN = ds_rstn_q;
    assign pll.READY   = ready_q;
    assign pll.FAULT   = fault_q;
    assign pll.STATE   = state;

endmodule
